unidade_busca: RTL
==================

// Module: unidade_busca
// PURPOSE
//  Instruction fetch stage for the 32-bit core. Owns the PC, fetches instruction words
//  over a req/ack memory handshake and holds the current instruction for decode.
//  Drives the immediate field and the extension-select bit consumed directly by the
//  sign extender downstream. Accepts redirects (jump/branch) from the control unit.
// PARAMETERS
//  LARGURA_PC   32   PC/address width in bits; word-addressed memory
//  PC_INICIAL   0    PC value loaded on reset
// PORTS
//  Clock         in   1    single clock; all state updates on rising edge
//  Reset         in   1    asynchronous, active-low reset
//  MemReq        out  1    fetch request; MemEnd held stable while high
//  MemEnd        out  LARGURA_PC  fetch address
//  MemAck        in   1    memory returns MemDado this cycle; ends request
//  MemDado       in   32   instruction word, valid when MemAck=1
//  Avanca        in   1    decode consumes held instruction this cycle
//  Desvio        in   1    redirect request, one-cycle pulse
//  DesvioAlvo    in   LARGURA_PC  redirect target, valid with Desvio
//  Instrucao     out  32   held instruction word
//  InstrValida   out  1    Instrucao/PCInstr/ConstanteExt/ControleExt valid
//  PCInstr       out  LARGURA_PC  address Instrucao was fetched from
//  ConstanteExt  out  16   Instrucao[15:0], to extender ConstanteIn
//  ControleExt   out  1    1 if opcode==OP_JUMP (12-bit extension), else 0
// BEHAVIOUR
//  Reset (async, Reset=0): PC=PC_INICIAL, state=OCIOSO, MemReq=0, MemEnd=PC_INICIAL,
//   Instrucao=0, InstrValida=0, PCInstr=0, ConstanteExt=0, ControleExt=0, descarte=0.
//   Reset mid-fetch abandons the request; a late MemAck after release is ignored (OCIOSO).
//  States:
//   OCIOSO  : one cycle after reset release -> BUSCA.
//   BUSCA   : MemReq=1, MemEnd=PC. On MemAck: if descarte=0 latch MemDado into Instrucao,
//             PCInstr=PC, PC=PC+1, InstrValida=1 -> ENTREGA; if descarte=1 drop data,
//             clear descarte, PC=alvo_pendente, stay BUSCA (new request next cycle).
//   ENTREGA : MemReq=0, outputs held. Avanca=1 -> InstrValida=0, BUSCA next cycle.
//  Latency: MemAck in cycle t -> InstrValida=1 in t+1; Avanca in t -> MemReq=1 in t+1.
//  Redirect (Desvio=1), priority over Avanca:
//   ENTREGA: InstrValida=0, PC=DesvioAlvo, -> BUSCA.
//   BUSCA, MemAck same cycle: data dropped, PC=DesvioAlvo, stay BUSCA.
//   BUSCA, no MemAck: MemEnd must not change while MemReq=1; set descarte=1, store
//    alvo_pendente; a second Desvio before ack overwrites alvo_pendente.
//   OCIOSO: PC=DesvioAlvo, -> BUSCA.
//  PC arithmetic: PC+1 modulo 2^LARGURA_PC (wraps all-ones -> 0, no flag).
//  ConstanteExt/ControleExt registered with Instrucao, never combinational from MemDado;
//   opcode = Instrucao[31:26]. Outputs hold value while InstrValida=0 except on reset.
//  Avanca while InstrValida=0 is ignored.
// STRUCTURE
//  Package proc_pkg: opcode constants (OP_JUMP, OP_LOADLIT, OP_LCL, OP_LCH), opcode field
//   bounds [31:26], state encoding OCIOSO/BUSCA/ENTREGA, EXT_16/EXT_12 select values.
//  Single module; no sub-module. FSM + PC register + instruction register.
// TESTING
//  1 Reset release, memory acks after 2 cycles with 0x0400_1234 (loadlit) -> MemEnd=0,
//    InstrValida=1 one cycle after ack, ConstanteExt=0x1234, ControleExt=0, PCInstr=0.
//  2 Jump word (opcode=OP_JUMP, [15:0]=0x0ABC), Avanca held 1, ack every cycle ->
//    ControleExt=1; back-to-back MemEnd 0,1,2 with one ENTREGA cycle between requests.
//  3 Desvio(alvo=0x40) while BUSCA at PC=5 unacked, ack 3 cycles later -> MemEnd stays 5
//    until ack, data dropped, InstrValida stays 0, next request MemEnd=0x40.
//  4 Desvio(alvo=0x80) and Avanca same cycle in ENTREGA -> InstrValida=0, next MemEnd=0x80.
//  5 PC_INICIAL=all-ones, one fetch + Avanca -> PCInstr=all-ones, next MemEnd=0.
//  6 Reset asserted mid-BUSCA with MemAck arriving during reset -> all outputs at reset
//    values, no instruction latched; normal fetch from PC_INICIAL after release.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the 32-bit core front end: opcode values, opcode field
// bounds, fetch-stage state encoding and sign-extender select values.
// No ports; imported by the fetch stage and anything decoding instruction words.
package proc_pkg;

    // Opcode field position inside an instruction word
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    // Opcode values
    localparam logic [OPC_W-1:0] OP_LOADLIT = 6'd1;
    localparam logic [OPC_W-1:0] OP_JUMP    = 6'd2;
    localparam logic [OPC_W-1:0] OP_LCL     = 6'd3;
    localparam logic [OPC_W-1:0] OP_LCH     = 6'd4;

    // Sign-extender mode select: 16-bit immediate or 12-bit jump offset
    localparam logic EXT_16 = 1'b0;
    localparam logic EXT_12 = 1'b1;

    // Fetch-stage states
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    // Extension mode implied by an instruction word's opcode
    function automatic logic sel_extensao(input logic [31:0] palavra);
        return (palavra[OPC_MSB:OPC_LSB] == OP_JUMP) ? EXT_12 : EXT_16;
    endfunction

endpackage

// File: rtl/unidade_busca.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake and
// holds the current instruction (plus its immediate and extension select) for decode.
// Ports: Clock/Reset (async active-low); MemReq/MemEnd/MemAck/MemDado memory side;
//   Avanca/Desvio/DesvioAlvo from control; Instrucao/InstrValida/PCInstr/ConstanteExt/
//   ControleExt to decode and the sign extender.
// Latency: MemAck in cycle t -> InstrValida in t+1; Avanca in t -> MemReq in t+1.
module unidade_busca
    import proc_pkg::*;
#(
    parameter int                    LARGURA_PC = 32,
    parameter logic [LARGURA_PC-1:0] PC_INICIAL = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic                  MemReq,
    output logic [LARGURA_PC-1:0] MemEnd,
    input  logic                  MemAck,
    input  logic [31:0]           MemDado,
    input  logic                  Avanca,
    input  logic                  Desvio,
    input  logic [LARGURA_PC-1:0] DesvioAlvo,
    output logic [31:0]           Instrucao,
    output logic                  InstrValida,
    output logic [LARGURA_PC-1:0] PCInstr,
    output logic [15:0]           ConstanteExt,
    output logic                  ControleExt
);

    estado_t               estado_q, estado_d;
    logic [LARGURA_PC-1:0] pc_q, pc_d;
    // A redirect arrived while a request was outstanding: the address could not
    // change mid-request, so the returning word is dropped and alvo_q is fetched next.
    logic                  descarte_q, descarte_d;
    logic [LARGURA_PC-1:0] alvo_q, alvo_d;
    logic [31:0]           instr_q, instr_d;
    logic                  valido_q, valido_d;
    logic [LARGURA_PC-1:0] pcinstr_q, pcinstr_d;
    logic [15:0]           const_q, const_d;
    logic                  ctrl_q, ctrl_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado_q   <= OCIOSO;
            pc_q       <= PC_INICIAL;
            descarte_q <= 1'b0;
            alvo_q     <= '0;
            instr_q    <= '0;
            valido_q   <= 1'b0;
            pcinstr_q  <= '0;
            const_q    <= '0;
            ctrl_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            pc_q       <= pc_d;
            descarte_q <= descarte_d;
            alvo_q     <= alvo_d;
            instr_q    <= instr_d;
            valido_q   <= valido_d;
            pcinstr_q  <= pcinstr_d;
            const_q    <= const_d;
            ctrl_q     <= ctrl_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        pc_d       = pc_q;
        descarte_d = descarte_q;
        alvo_d     = alvo_q;
        instr_d    = instr_q;
        valido_d   = valido_q;
        pcinstr_d  = pcinstr_q;
        const_d    = const_q;
        ctrl_d     = ctrl_q;

        case (estado_q)
            OCIOSO: begin
                if (Desvio) begin
                    pc_d = DesvioAlvo;
                end
                estado_d = BUSCA;
            end

            BUSCA: begin
                if (MemAck) begin
                    if (Desvio) begin
                        // Newest redirect wins over any earlier pending one
                        pc_d       = DesvioAlvo;
                        descarte_d = 1'b0;
                    end else if (descarte_q) begin
                        pc_d       = alvo_q;
                        descarte_d = 1'b0;
                    end else begin
                        instr_d   = MemDado;
                        const_d   = MemDado[15:0];
                        ctrl_d    = sel_extensao(MemDado);
                        pcinstr_d = pc_q;
                        pc_d      = pc_q + LARGURA_PC'(1);
                        valido_d  = 1'b1;
                        estado_d  = ENTREGA;
                    end
                end else if (Desvio) begin
                    // MemEnd must stay put until the ack; remember where to go
                    descarte_d = 1'b1;
                    alvo_d     = DesvioAlvo;
                end
            end

            ENTREGA: begin
                if (Desvio) begin
                    pc_d     = DesvioAlvo;
                    valido_d = 1'b0;
                    estado_d = BUSCA;
                end else if (Avanca) begin
                    valido_d = 1'b0;
                    estado_d = BUSCA;
                end
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign MemReq       = (estado_q == BUSCA);
    assign MemEnd       = pc_q;
    assign Instrucao    = instr_q;
    assign InstrValida  = valido_q;
    assign PCInstr      = pcinstr_q;
    assign ConstanteExt = const_q;
    assign ControleExt  = ctrl_q;

endmodule
